mem_arbiter: RTL and testbench

Two-port arbiter that shares the single memory unit between the CPU instruction-fetch port (A) and the CPU data port (B). It sits between the CPU bus interfaces and the memory unit's address/data/we/start/busy/q handshake. It latches one request at a time, sequences the start/busy protocol, and returns read data with a one-cycle ack. Arbitration is round-robin. A watchdog terminates transactions the memory unit never completes.

---
 rtl/mem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one start/busy memory unit between the instruction
// port (A) and the data port (B), with a watchdog that force-completes stalled accesses.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic [26:0] a_addr,
    input  logic [31:0] a_data,
    input  logic        a_we,
    output logic        a_ack,
    output logic [31:0] a_q,
    input  logic        b_req,
    input  logic [26:0] b_addr,
    input  logic [31:0] b_data,
    input  logic        b_we,
    output logic        b_ack,
    output logic [31:0] b_q,
    output logic [26:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_we,
    output logic        mem_start,
    input  logic        mem_busy,
    input  logic [31:0] mem_q,
    input  logic        mem_init_done,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
    // The edge on which the timer would reach TIMEOUT is the forced-completion edge.
    localparam logic [9:0] TIMER_LAST = 10'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [9:0]  timer_q, timer_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [26:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_start_q, mem_start_d;
    logic        a_ack_q, a_ack_d;
    logic        b_ack_q, b_ack_d;
    logic [31:0] a_q_q, a_q_d;
    logic [31:0] b_q_q, b_q_d;
    logic        timeout_err_q, timeout_err_d;

    logic        grant_valid_s;
    logic        grant_port_s;
    logic        finish_s;
    logic        forced_s;
    logic [31:0] ret_data_s;

    // Port selection: single requester wins, a tie goes to the port not granted last.
    always_comb begin
        grant_valid_s = mem_init_done && !mem_busy && (a_req || b_req);
        if (a_req && b_req) begin
            grant_port_s = (last_grant_q == PORT_A) ? PORT_B : PORT_A;
        end else if (b_req) begin
            grant_port_s = PORT_B;
        end else begin
            grant_port_s = PORT_A;
        end
    end

    // Next-state and next-output computation for the transaction sequencer.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        mem_addr_d    = mem_addr_q;
        mem_data_d    = mem_data_q;
        mem_we_d      = mem_we_q;
        mem_start_d   = mem_start_q;
        a_ack_d       = 1'b0;
        b_ack_d       = 1'b0;
        a_q_d         = a_q_q;
        b_q_d         = b_q_q;
        timeout_err_d = timeout_err_q;
        finish_s      = 1'b0;
        forced_s      = 1'b0;
        ret_data_s    = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    state_d      = ST_ISSUE;
                    timer_d      = 10'd0;
                    owner_d      = grant_port_s;
                    last_grant_d = grant_port_s;
                    mem_start_d  = 1'b1;
                    if (grant_port_s == PORT_B) begin
                        mem_addr_d = b_addr;
                        mem_data_d = b_data;
                        mem_we_d   = b_we;
                    end else begin
                        mem_addr_d = a_addr;
                        mem_data_d = a_data;
                        mem_we_d   = a_we;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_busy) begin
                    state_d = ST_WAIT;
                end else if (timer_q == TIMER_LAST) begin
                    finish_s = 1'b1;
                    forced_s = 1'b1;
                end else begin
                    timer_d = timer_q + 10'd1;
                end
            end
            ST_WAIT: begin
                // A busy fall on the watchdog edge still counts as a normal completion.
                if (!mem_busy) begin
                    finish_s = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    finish_s = 1'b1;
                    forced_s = 1'b1;
                end else begin
                    timer_d = timer_q + 10'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                mem_start_d = 1'b0;
            end
        endcase

        if (finish_s) begin
            state_d     = ST_DONE;
            mem_start_d = 1'b0;
            ret_data_s  = forced_s ? 32'd0 : mem_q;
            if (owner_q == PORT_B) begin
                b_ack_d = 1'b1;
                b_q_d   = ret_data_s;
            end else begin
                a_ack_d = 1'b1;
                a_q_d   = ret_data_s;
            end
            if (forced_s) begin
                timeout_err_d = 1'b1;
            end else begin
                timeout_err_d = timeout_err_q;
            end
        end else begin
            ret_data_s = 32'd0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= 10'd0;
            owner_q       <= PORT_A;
            last_grant_q  <= PORT_B;
            mem_addr_q    <= 27'd0;
            mem_data_q    <= 32'd0;
            mem_we_q      <= 1'b0;
            mem_start_q   <= 1'b0;
            a_ack_q       <= 1'b0;
            b_ack_q       <= 1'b0;
            a_q_q         <= 32'd0;
            b_q_q         <= 32'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            mem_we_q      <= mem_we_d;
            mem_start_q   <= mem_start_d;
            a_ack_q       <= a_ack_d;
            b_ack_q       <= b_ack_d;
            a_q_q         <= a_q_d;
            b_q_q         <= b_q_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign mem_we      = mem_we_q;
    assign mem_start   = mem_start_q;
    assign a_ack       = a_ack_q;
    assign b_ack       = b_ack_q;
    assign a_q         = a_q_q;
    assign b_q         = b_q_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a start/busy memory model plus a queue of expected completions
// that each scenario task fills when it drives a request and drains when an ack appears.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        a_req, b_req, a_we, b_we;
    logic [26:0] a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ack, b_ack;
    logic [31:0] a_q, b_q;
    logic [26:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we, mem_start;
    logic        mem_busy;
    logic [31:0] mem_q;
    logic        mem_init_done;
    logic        timeout_err;

    int checks;
    int failures;

    typedef struct {
        logic        port;
        logic [31:0] q;
        logic [26:0] addr;
    } exp_t;
    exp_t sb[$];

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_we(a_we), .a_ack(a_ack), .a_q(a_q),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_we(b_we), .b_ack(b_ack), .b_q(b_q),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_start(mem_start),
        .mem_busy(mem_busy), .mem_q(mem_q), .mem_init_done(mem_init_done),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory unit model: samples start on posedge, drives busy/q on negedge.
    int          mem_lat  = 1;
    logic        mem_hang = 1'b0;
    logic        armed    = 1'b1;
    int          busy_cnt = 0;
    logic        start_smp = 1'b0;
    logic [26:0] addr_smp, cap_addr;
    logic [31:0] data_smp, cap_data;
    logic        we_smp, cap_we;

    function automatic logic [31:0] mem_val(input logic [26:0] addr);
        if (addr == 27'hC00005) return 32'hDEADBEEF;
        return {5'd0, addr} ^ 32'h5A5A_5A5A;
    endfunction

    initial begin
        mem_busy = 1'b0;
        mem_q    = 32'd0;
        cap_addr = 27'd0;
        cap_data = 32'd0;
        cap_we   = 1'b0;
        addr_smp = 27'd0;
        data_smp = 32'd0;
        we_smp   = 1'b0;
    end

    always @(posedge clk) begin
        start_smp <= mem_start;
        addr_smp  <= mem_addr;
        data_smp  <= mem_data;
        we_smp    <= mem_we;
    end

    always @(negedge clk) begin
        if (mem_busy) begin
            if (busy_cnt <= 1) begin
                mem_busy <= 1'b0;
                mem_q    <= mem_val(cap_addr);
            end else begin
                busy_cnt <= busy_cnt - 1;
            end
        end else if (start_smp && armed && !mem_hang) begin
            mem_busy <= 1'b1;
            busy_cnt <= mem_lat;
            cap_addr <= addr_smp;
            cap_data <= data_smp;
            cap_we   <= we_smp;
            armed    <= 1'b0;
        end else if (!start_smp) begin
            armed <= 1'b1;
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_start, mem_we, a_ack, b_ack, timeout_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got start/we/aack/back/terr=%b expected 00000",
                     {mem_start, mem_we, a_ack, b_ack, timeout_err});
        end
        checks++;
        if (mem_addr !== 27'd0 || mem_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_mem_regs: got addr=%h data=%h expected 0", mem_addr, mem_data);
        end
        checks++;
        if (a_q !== 32'd0 || b_q !== 32'd0) begin
            failures++;
            $display("FAIL reset_q: got a_q=%h b_q=%h expected 0", a_q, b_q);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        exp_t e;
        int   n;
        logic seen, b_bad;
        mem_lat = 1;
        @(negedge clk);
        a_addr = 27'hC00005; a_we = 1'b0; a_req = 1'b1;
        e.port = 1'b0; e.q = 32'hDEADBEEF; e.addr = 27'hC00005;
        sb.push_back(e);
        n = 0; seen = 1'b0; b_bad = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (b_ack) b_bad = 1'b1;
            if (a_ack) seen = 1'b1;
        end
        a_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!seen || n != 4) begin
            failures++;
            $display("FAIL read_latency: got seen=%0d cycles=%0d expected ack after 4", seen, n);
        end
        checks++;
        if (a_q !== e.q) begin
            failures++;
            $display("FAIL read_data: got a_q=%h expected %h", a_q, e.q);
        end
        checks++;
        if (b_ack !== 1'b0 || b_bad) begin
            failures++;
            $display("FAIL read_b_quiet: got b_ack activity expected none");
        end
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b0 || a_q !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL read_ack_pulse: got a_ack=%b a_q=%h expected 0/deadbeef", a_ack, a_q);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   n, last_n, acks;
        logic prev_ack;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mem_lat = 1;
        a_addr = 27'h000010; a_we = 1'b0;
        b_addr = 27'h800000; b_we = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e.port = i[0];
            e.addr = i[0] ? 27'h800000 : 27'h000010;
            e.q    = mem_val(e.addr);
            sb.push_back(e);
        end
        n = 0; last_n = 0; acks = 0; prev_ack = 1'b0;
        while (acks < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (prev_ack) begin
                checks++;
                if (a_ack !== 1'b0 || b_ack !== 1'b0) begin
                    failures++;
                    $display("FAIL rr_ack_width: got a_ack=%b b_ack=%b expected 0 0", a_ack, b_ack);
                end
            end
            prev_ack = a_ack | b_ack;
            if (a_ack || b_ack) begin
                e = sb.pop_front();
                acks++;
                if (acks == 4) begin
                    a_req = 1'b0; b_req = 1'b0;
                end
                checks++;
                if (b_ack !== e.port || a_ack !== ~e.port) begin
                    failures++;
                    $display("FAIL rr_order: ack #%0d got a=%b b=%b expected port %0d",
                             acks, a_ack, b_ack, e.port);
                end
                checks++;
                if (mem_addr !== e.addr) begin
                    failures++;
                    $display("FAIL rr_mem_addr: got %h expected %h", mem_addr, e.addr);
                end
                checks++;
                if ((e.port ? b_q : a_q) !== e.q) begin
                    failures++;
                    $display("FAIL rr_data: got %h expected %h", e.port ? b_q : a_q, e.q);
                end
                checks++;
                if (n - last_n != ((acks == 1) ? 4 : 5)) begin
                    failures++;
                    $display("FAIL rr_spacing: ack #%0d got gap %0d expected %0d",
                             acks, n - last_n, (acks == 1) ? 4 : 5);
                end
                last_n = n;
            end
        end
        checks++;
        if (acks != 4) begin
            failures++;
            $display("FAIL rr_timeout: got %0d acks expected 4", acks);
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write_b();
        exp_t e;
        int   n;
        logic seen;
        mem_lat = 2;
        @(negedge clk);
        b_addr = 27'h000100; b_data = 32'h12345678; b_we = 1'b1; b_req = 1'b1;
        e.port = 1'b1; e.addr = 27'h000100; e.q = 32'd0;
        sb.push_back(e);
        n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (b_ack) seen = 1'b1;
        end
        b_req = 1'b0; b_we = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!seen || n != 5 || a_ack !== 1'b0) begin
            failures++;
            $display("FAIL write_ack: got seen=%0d cycles=%0d a_ack=%b expected b ack after 5",
                     seen, n, a_ack);
        end
        checks++;
        if (cap_we !== 1'b1 || cap_addr !== e.addr || cap_data !== 32'h12345678) begin
            failures++;
            $display("FAIL write_latched: got we=%b addr=%h data=%h expected 1/%h/12345678",
                     cap_we, cap_addr, cap_data, e.addr);
        end
        checks++;
        if (mem_start !== 1'b0) begin
            failures++;
            $display("FAIL write_start_drop: got mem_start=%b expected 0", mem_start);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_watchdog();
        exp_t e;
        int   n;
        logic seen;
        mem_hang = 1'b1;
        @(negedge clk);
        a_addr = 27'h000ABC; a_we = 1'b0; a_req = 1'b1;
        e.port = 1'b0; e.addr = 27'h000ABC; e.q = 32'd0;
        sb.push_back(e);
        n = 0; seen = 1'b0;
        while (!seen && n < 1100) begin
            @(negedge clk);
            n++;
            if (a_ack) seen = 1'b1;
        end
        a_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!seen || n != 1024) begin
            failures++;
            $display("FAIL wd_latency: got seen=%0d cycles=%0d expected ack after 1024", seen, n);
        end
        checks++;
        if (a_q !== e.q || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL wd_result: got a_q=%h terr=%b expected 0/1", a_q, timeout_err);
        end
        repeat (2) @(negedge clk);
        mem_hang = 1'b0;
        mem_lat = 1;
        repeat (2) @(negedge clk);
        a_addr = 27'h000123; a_req = 1'b1;
        e.port = 1'b0; e.addr = 27'h000123; e.q = mem_val(27'h000123);
        sb.push_back(e);
        n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (a_ack) seen = 1'b1;
        end
        a_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!seen || a_q !== e.q || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL wd_sticky: got seen=%0d a_q=%h terr=%b expected 1/%h/1",
                     seen, a_q, timeout_err, e.q);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_init_gating();
        exp_t e;
        int   n;
        logic seen;
        mem_lat = 1;
        mem_init_done = 1'b0;
        @(negedge clk);
        a_addr = 27'h0000F0; a_we = 1'b0; a_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (mem_start !== 1'b0) begin
                failures++;
                $display("FAIL init_gate: cycle %0d got mem_start=%b expected 0", i, mem_start);
            end
        end
        mem_init_done = 1'b1;
        e.port = 1'b0; e.addr = 27'h0000F0; e.q = mem_val(27'h0000F0);
        sb.push_back(e);
        @(negedge clk);
        checks++;
        if (mem_start !== 1'b1) begin
            failures++;
            $display("FAIL init_release: got mem_start=%b expected 1", mem_start);
        end
        n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (a_ack) seen = 1'b1;
        end
        a_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!seen || a_q !== e.q) begin
            failures++;
            $display("FAIL init_read: got seen=%0d a_q=%h expected 1/%h", seen, a_q, e.q);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_wait();
        exp_t e;
        int   n;
        logic seen, ack_bad;
        mem_lat = 6;
        @(negedge clk);
        a_addr = 27'h0003C0; a_we = 1'b0; a_req = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mem_lat = 1;
        checks++;
        if (mem_start !== 1'b0 || a_ack !== 1'b0 || b_ack !== 1'b0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait_clear: got start=%b aack=%b back=%b terr=%b expected 0000",
                     mem_start, a_ack, b_ack, timeout_err);
        end
        n = 0; ack_bad = 1'b0;
        while (mem_start !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
            if (a_ack || b_ack) ack_bad = 1'b1;
        end
        checks++;
        if (n != 5 || ack_bad) begin
            failures++;
            $display("FAIL rst_wait_stall: got regrant after %0d cycles ack_bad=%0d expected 5/0",
                     n, ack_bad);
        end
        e.port = 1'b0; e.addr = 27'h0003C0; e.q = mem_val(27'h0003C0);
        sb.push_back(e);
        n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (a_ack) seen = 1'b1;
        end
        a_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!seen || n != 3 || a_q !== e.q) begin
            failures++;
            $display("FAIL rst_wait_regrant: got seen=%0d cycles=%0d a_q=%h expected 1/3/%h",
                     seen, n, a_q, e.q);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1;
        a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
        a_addr = 27'd0; b_addr = 27'd0; a_data = 32'd0; b_data = 32'd0;
        mem_init_done = 1'b1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_b();
        test_watchdog();
        test_init_gating();
        test_reset_wait();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

endmodule
